adder_tree_result_collector: RTL

Receiving end of the adder-tree layer protocol. It accepts the final-layer sum and its data-valid pulse, which carry no backpressure, and buffers the sums in a FIFO. It then presents them downstream on a ready/valid stream. It sits after the last adder tree layer in the TDC datapath. Sums that arrive while the FIFO is full are dropped and reported.

---
 rtl/adder_tree_result_collector.sv | 97 +++++++++
 1 files changed

// File: rtl/adder_tree_result_collector.sv
// Collects final adder-tree sums into a FIFO and streams them out on ready/valid.
// Optional drop counter is built when ADDER_TREE_COLLECTOR_DROP_CNT_EN is defined.
module adder_tree_result_collector #(
  parameter int WIDTH_PER_OUT = 17,
  parameter int DEPTH         = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_N,
  input  logic [WIDTH_PER_OUT-1:0] i_Sum,
  input  logic                     i_Data_Valid,
  output logic [WIDTH_PER_OUT-1:0] o_Data,
  output logic                     o_Data_Valid,
  input  logic                     i_Data_Ready,
  output logic [$clog2(DEPTH):0]   o_Fill_Level,
  output logic                     o_Overflow,
  input  logic                     i_Clear_Overflow
`ifdef ADDER_TREE_COLLECTOR_DROP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]     o_Drop_Count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH_PER_OUT-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic [AW:0]   fill_next;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic          ovf;

  assign full = (fill == FULL_LVL);
  assign pop  = o_Data_Valid & i_Data_Ready;
  assign push = i_Data_Valid & (~full | pop);
  assign drop = i_Data_Valid & full & ~pop;

  always_comb begin
    fill_next = fill;
    unique case (1'b1)
      push & ~pop: fill_next = fill + 1'b1;
      pop & ~push: fill_next = fill - 1'b1;
      default:     fill_next = fill;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fill <= fill_next;
    end
  end

  // Storage needs no reset; the output is masked whenever nothing is held.
  always_ff @(posedge i_Clk) begin
    if (i_Reset_N && push) mem[wr_ptr] <= i_Sum;
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_N)            ovf <= 1'b0;
    else if (drop)             ovf <= 1'b1;
    else if (i_Clear_Overflow) ovf <= 1'b0;
  end

`ifdef ADDER_TREE_COLLECTOR_DROP_CNT_EN
  logic [CNT_WIDTH-1:0] drop_cnt;

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_N) begin
      drop_cnt <= '0;
    end else if (i_Clear_Overflow) begin
      drop_cnt <= drop ? CNT_WIDTH'(1) : '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign o_Drop_Count = drop_cnt;
`endif

  assign o_Data_Valid = (fill != '0);
  assign o_Data       = o_Data_Valid ? mem[rd_ptr] : '0;
  assign o_Fill_Level = fill;
  assign o_Overflow   = ovf;

endmodule
